// File: rtl/norm_shift_pipe_pkg.sv
// norm_shift_pipe_pkg: shared FPU normalizer widths, shift-width helper and stage-2 result type
package norm_shift_pipe_pkg;
  localparam int MANT_W = 24;
  localparam int EXP_W = 8;
  function automatic int cw_of(input int w);
    return $clog2(w + 1);
  endfunction
  localparam int SHIFT_W = cw_of(MANT_W);
  typedef struct packed {
    logic [MANT_W-1:0]  mant;
    logic [EXP_W-1:0]   exp;
    logic [SHIFT_W-1:0] shift;
    logic               zero;
    logic               sub;
  } norm_res_t;
endpackage

// File: rtl/norm_shift_pipe_lzc.sv
// lzc: combinational leading-zero counter; an all-zero input counts as WIDTH
module lzc
  import norm_shift_pipe_pkg::*;
#(
  parameter int WIDTH = MANT_W
) (
  input  logic [WIDTH-1:0]        mant,
  output logic [cw_of(WIDTH)-1:0] cnt,
  output logic                    all_zero
);
  localparam int CW = cw_of(WIDTH);
  // later (higher) set bits overwrite, so the MSB-most one wins
  always_comb begin
    cnt = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++)
      if (mant[i]) cnt = CW'(WIDTH - 1 - i);
  end
  assign all_zero = ~|mant;
endmodule

// File: rtl/norm_shift_pipe.sv
// norm_shift_pipe: two-stage mantissa normalizer; exponent decrement clamps at 0 to form subnormals
module norm_shift_pipe
  import norm_shift_pipe_pkg::*;
#(
  parameter int WIDTH = MANT_W,
  parameter int EW = EXP_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [WIDTH-1:0]        InMant,
  input  logic [EW-1:0]           InExp,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic [WIDTH-1:0]        OutMant,
  output logic [EW-1:0]           OutExp,
  output logic [cw_of(WIDTH)-1:0] OutShift,
  output logic                    OutZero,
  output logic                    OutSub
);
  localparam int CW = cw_of(WIDTH);
  localparam int MW = CW > EW ? CW : EW;
  logic             s1_valid, s2_valid, s1_ready, s2_ready, all_zero, le;
  logic [WIDTH-1:0] s1_mant;
  logic [EW-1:0]    s1_exp;
  logic [CW-1:0]    lz, sh;
  norm_res_t        s2, nxt;
  assign s2_ready = ~s2_valid | OutReady;
  assign s1_ready = ~s1_valid | s2_ready;
  assign InReady = reset_n & s1_ready;
  lzc #(.WIDTH(WIDTH)) u_lzc (.mant(s1_mant), .cnt(lz), .all_zero(all_zero));
  // when the exponent cannot absorb the full shift, shift only by the exponent
  always_comb begin
    le = MW'(lz) <= MW'(s1_exp);
    sh = all_zero ? '0 : le ? lz : CW'(MW'(s1_exp));
    nxt.mant = s1_mant << sh;
    nxt.exp = (all_zero | ~le) ? '0 : s1_exp - EW'(lz);
    nxt.shift = sh;
    nxt.zero = all_zero;
    nxt.sub = ~all_zero & ~le;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_mant <= '0;
      s1_exp <= '0;
      s2 <= '0;
    end else begin
      if (s1_ready) s1_valid <= InValid;
      if (s2_ready) s2_valid <= s1_valid;
      if (InValid & s1_ready) begin
        s1_mant <= InMant;
        s1_exp <= InExp;
      end
      if (s1_valid & s2_ready) s2 <= nxt;
    end
  end
  assign OutValid = s2_valid;
  assign OutMant = s2.mant;
  assign OutExp = s2.exp;
  assign OutShift = s2.shift;
  assign OutZero = s2.zero;
  assign OutSub = s2.sub;
endmodule

// File: tb/tb_norm_shift_pipe.sv
// tb_norm_shift_pipe: scoreboard bench with a behavioural normalize model, directed and random traffic
module tb_norm_shift_pipe;
  logic        clk = 0, reset_n = 1, InValid = 0, InReady, OutValid, OutReady = 1, OutZero, OutSub;
  logic [23:0] InMant = 0, OutMant;
  logic [7:0]  InExp = 0, OutExp;
  logic [4:0]  OutShift;
  logic [38:0] q[$];
  int checks = 0, errors = 0, pushes = 0, pops = 0;

  norm_shift_pipe dut (.clk(clk), .reset_n(reset_n), .InValid(InValid), .InReady(InReady),
    .InMant(InMant), .InExp(InExp), .OutValid(OutValid), .OutReady(OutReady), .OutMant(OutMant),
    .OutExp(OutExp), .OutShift(OutShift), .OutZero(OutZero), .OutSub(OutSub));

  always #5 clk = ~clk;

  function automatic logic [38:0] model(logic [23:0] m, logic [7:0] e);
    int lz = 0, sh, ex;
    bit s;
    if (m == 0) return {24'd0, 8'd0, 5'd0, 1'b1, 1'b0};
    while (!m[23 - lz]) lz++;
    if (lz <= int'(e)) begin sh = lz; ex = int'(e) - lz; s = 0; end
    else begin sh = int'(e); ex = 0; s = 1; end
    return {24'(m << sh), 8'(ex), 5'(sh), 1'b0, s};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [38:0] outs();
    return {OutMant, OutExp, OutShift, OutZero, OutSub};
  endfunction

  always @(negedge reset_n) q.delete();

  always @(negedge clk) if (reset_n) begin
    if (InValid && InReady) begin q.push_back(model(InMant, InExp)); pushes++; end
    if (OutValid && OutReady) begin
      pops++;
      if (q.size() == 0) chk("unexpected_output", 1, 0);
      else chk("scoreboard", outs(), q.pop_front());
    end
  end

  int stalls = 0;
  task automatic send(logic [23:0] m, logic [7:0] e);
    int n = 0;
    InValid = 1; InMant = m; InExp = e;
    @(negedge clk);
    while (!InReady && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) chk("accept_timeout", 0, 1);
    stalls += n;
    @(posedge clk); #1;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin n++; @(negedge clk); end while (!OutValid && n < 20);
    if (!OutValid) chk("output_timeout", 0, 1);
  endtask

  task automatic idle();
    InValid = 0;
  endtask

  task automatic drain();
    int n = 0;
    idle(); OutReady = 1;
    while (q.size() != 0 && n < 20) begin n++; @(negedge clk); end
    @(posedge clk); #1;
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    int n;
    logic [38:0] snap;
    bit took;
    #2 reset_n = 0;
    #1;
    chk("reset_outvalid", OutValid, 0);
    chk("reset_inready", InReady, 0);
    chk("reset_outs", outs(), 0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1;
    @(posedge clk); #1;
    chk("post_reset_inready", InReady, 1);

    send(24'h000800, 8'd100); idle();
    wait_out(n);
    chk("latency", n, 2);
    chk("basic", outs(), {24'h800000, 8'd88, 5'd12, 1'b0, 1'b0});
    @(posedge clk); #1;

    send(24'h000800, 8'd5); idle(); wait_out(n);
    chk("subnormal", outs(), {24'h010000, 8'd0, 5'd5, 1'b0, 1'b1});
    @(posedge clk); #1;
    send(24'h000800, 8'd12); idle(); wait_out(n);
    chk("equal_boundary", outs(), {24'h800000, 8'd0, 5'd12, 1'b0, 1'b0});
    @(posedge clk); #1;
    send(24'h000000, 8'd77); idle(); wait_out(n);
    chk("zero_input", outs(), {24'h000000, 8'd0, 5'd0, 1'b1, 1'b0});
    @(posedge clk); #1;
    send(24'h800000, 8'd127); idle(); wait_out(n);
    chk("already_normal", outs(), {24'h800000, 8'd127, 5'd0, 1'b0, 1'b0});
    drain();

    stalls = 0;
    send(24'h800000, 8'd127); send(24'h000001, 8'd200); send(24'h000001, 8'd3);
    send(24'h0F0000, 8'd1); send(24'h000000, 8'd9); send(24'h123456, 8'd0);
    send(24'h400000, 8'd1); send(24'h00ABCD, 8'd255);
    chk("stream_no_stall", stalls, 0);
    drain();

    OutReady = 0;
    send(24'h000100, 8'd50); send(24'h002000, 8'd2);
    InValid = 1; InMant = 24'h000003; InExp = 8'd30;
    @(negedge clk); snap = outs();
    for (int i = 0; i < 5; i++) begin
      chk("stall_inready", InReady, 0);
      chk("stall_outvalid", OutValid, 1);
      chk("stall_hold", outs(), snap);
      @(negedge clk);
    end
    @(posedge clk); #1; OutReady = 1;
    n = 0;
    @(negedge clk);
    while (!InReady && n < 10) begin n++; @(negedge clk); end
    @(posedge clk); #1;
    drain();
    chk("bp_pushes_popped", pops, pushes);

    send(24'h000400, 8'd60); send(24'h000010, 8'd4); idle();
    #2 reset_n = 0;
    #1;
    chk("midreset_outvalid", OutValid, 0);
    chk("midreset_outs", outs(), 0);
    chk("midreset_inready", InReady, 0);
    #3 reset_n = 1;
    @(posedge clk); #1;
    chk("post_midreset_inready", InReady, 1);
    pushes = 0; pops = 0;
    send(24'h000400, 8'd60); idle(); wait_out(n);
    chk("post_midreset_latency", n, 2);
    chk("post_midreset_result", outs(), {24'h800000, 8'd47, 5'd13, 1'b0, 1'b0});
    drain();

    took = 1;
    for (int c = 0; c < 800; c++) begin
      if (took || !InValid) begin
        InValid = ($urandom % 3) != 0;
        InMant = 24'($urandom) >> $urandom_range(0, 24);
        InExp = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom);
      end
      OutReady = ($urandom % 4) != 0;
      @(negedge clk);
      took = InValid && InReady;
      @(posedge clk); #1;
    end
    drain();
    chk("random_pushes_popped", pops, pushes);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
